// File: rtl/store_buffer_if.sv
// Request/response and memory-port bundle for the store buffer.
//   slave  : the store buffer side (takes requests, drives memory requests).
//   master : the environment side (execute-stage requester plus data memory).
// Request side : req_valid, req_addr, req_wdata, req_wstrb, req_fence -> resp_ready, resp_rdata
// Memory side  : mem_valid, mem_addr, mem_wdata, mem_wstrb -> mem_ready, mem_rdata
interface store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic              req_valid;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_wstrb;
  logic              req_fence;
  logic              resp_ready;
  logic [DW-1:0]     resp_rdata;

  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wstrb;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, req_fence, mem_ready, mem_rdata,
    output resp_ready, resp_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, req_fence, mem_ready, mem_rdata,
    input  resp_ready, resp_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/store_buffer.sv
// Data-side memory front end. Stores are posted into a DEPTH-entry FIFO and
// acknowledged at once, then drained to memory in order. Loads are forwarded
// from the buffer when buffered bytes cover the whole word, go to memory when
// nothing matches, and wait for the matching entries to drain on partial
// overlap. Fences complete once the buffer is empty and memory is idle.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   bus_io : store_buffer_if.slave (request/response and memory port)
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus_io
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WW = AW - 2;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
  logic [WW-1:0]     ent_addr_q [DEPTH];
  logic [WW-1:0]     ent_addr_d [DEPTH];
  logic [DW-1:0]     ent_data_q [DEPTH];
  logic [DW-1:0]     ent_data_d [DEPTH];
  logic [SW-1:0]     ent_strb_q [DEPTH];
  logic [SW-1:0]     ent_strb_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PW:0]       count_q, count_d;

  logic              resp_ready_q, resp_ready_d;
  logic [DW-1:0]     resp_rdata_q, resp_rdata_d;
  logic              mem_valid_q, mem_valid_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]     mem_wstrb_q, mem_wstrb_d;

  // Request decode. The request is ignored in the cycle the response is out.
  logic          req_act, is_fence, is_store, is_load;
  logic [WW-1:0] req_word;
  logic          unused_addr_lsb;

  assign req_act         = bus_io.req_valid & ~resp_ready_q;
  assign is_fence        = bus_io.req_fence;
  assign is_store        = ~is_fence & (|bus_io.req_wstrb);
  assign is_load         = ~is_fence & ~(|bus_io.req_wstrb);
  assign req_word        = bus_io.req_addr[AW-1:2];
  assign unused_addr_lsb = ^bus_io.req_addr[1:0];

  // Entry slots in age order, oldest (head) first.
  logic [PW-1:0] age_idx [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign age_idx[g] = head_q + PW'(g);
  end

  // Forwarding: walk oldest to youngest so younger bytes overwrite older ones.
  logic [SW-1:0] fwd_cover;
  logic [DW-1:0] fwd_data;
  always_comb begin
    fwd_cover = '0;
    fwd_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid_q[age_idx[i]] && (ent_addr_q[age_idx[i]] == req_word)) begin
        fwd_cover = fwd_cover | ent_strb_q[age_idx[i]];
        for (int unsigned b = 0; b < SW; b++) begin
          if (ent_strb_q[age_idx[i]][b]) begin
            fwd_data[8*b +: 8] = ent_data_q[age_idx[i]][8*b +: 8];
          end
        end
      end
    end
  end

  logic pop, full, push, load_hit, load_miss, fence_done;

  assign pop       = (state_q == StDrain) & bus_io.mem_ready;
  assign full      = (count_q == (PW+1)'(DEPTH));
  // A full buffer still accepts a store in the cycle the head pops.
  assign push      = req_act & is_store & (~full | pop);
  assign load_hit  = req_act & is_load & (state_q != StLoad) & (&fwd_cover);
  assign load_miss = req_act & is_load & (state_q == StIdle) & ~(|fwd_cover);
  // The last pop also completes a fence, so the response follows that mem_ready.
  assign fence_done = req_act & is_fence &
                      (((state_q == StIdle) & (count_q == '0)) |
                       (pop & (count_q == (PW+1)'(1))));

  always_comb begin
    state_d      = state_q;
    ent_valid_d  = ent_valid_q;
    ent_addr_d   = ent_addr_q;
    ent_data_d   = ent_data_q;
    ent_strb_d   = ent_strb_q;
    head_d       = head_q;
    tail_d       = tail_q;
    resp_ready_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;

    unique case (state_q)
      StIdle: begin
        // A clean-miss load takes the port ahead of any pending drain.
        if (load_miss) begin
          state_d     = StLoad;
          mem_valid_d = 1'b1;
          mem_addr_d  = {req_word, 2'b00};
          mem_wstrb_d = '0;
        end else if (count_q != '0) begin
          state_d     = StDrain;
          mem_valid_d = 1'b1;
          mem_addr_d  = {ent_addr_q[head_q], 2'b00};
          mem_wdata_d = ent_data_q[head_q];
          mem_wstrb_d = ent_strb_q[head_q];
        end
      end
      StLoad: begin
        if (bus_io.mem_ready) begin
          state_d      = StIdle;
          mem_valid_d  = 1'b0;
          resp_ready_d = 1'b1;
          resp_rdata_d = bus_io.mem_rdata;
        end
      end
      StDrain: begin
        if (bus_io.mem_ready) begin
          state_d     = StIdle;
          mem_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pop before push: when full, the pushed entry reuses the popped slot.
    if (pop) begin
      ent_valid_d[head_q] = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (push) begin
      ent_valid_d[tail_q] = 1'b1;
      ent_addr_d[tail_q]  = req_word;
      ent_data_d[tail_q]  = bus_io.req_wdata;
      ent_strb_d[tail_q]  = bus_io.req_wstrb;
      tail_d              = tail_q + PW'(1);
      resp_ready_d        = 1'b1;
    end
    if (load_hit) begin
      resp_ready_d = 1'b1;
      resp_rdata_d = fwd_data;
    end
    if (fence_done) begin
      resp_ready_d = 1'b1;
    end

    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ent_valid_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_strb_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_ready_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      ent_valid_q  <= ent_valid_d;
      ent_addr_q   <= ent_addr_d;
      ent_data_q   <= ent_data_d;
      ent_strb_q   <= ent_strb_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_ready_q <= resp_ready_d;
      resp_rdata_q <= resp_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

  assign bus_io.resp_ready = resp_ready_q;
  assign bus_io.resp_rdata = resp_rdata_q;
  assign bus_io.mem_valid  = mem_valid_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_wdata  = mem_wdata_q;
  assign bus_io.mem_wstrb  = mem_wstrb_q;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a table of single requests against an always-ready
// memory, then hand-written sequences for forwarding, partial hazards, a full
// buffer, fence/load ordering and reset during a drain.
module tb_store_buffer;
  logic clk;
  logic rst;
  logic mem_clear;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: initial contents 0xA500_0000 + word index.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (bus.mem_valid && bus.mem_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Present one request, wait for its response, then spend one idle cycle.
  // lat counts clock edges from presentation to the visible response.
  task automatic run_req(input logic fence, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output int lat, output logic [31:0] rdata);
    bus.req_valid = 1'b1;
    bus.req_fence = fence;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = strb;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.resp_ready && lat < 60);
    rdata = bus.resp_rdata;
    if (!bus.resp_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout actual=no_response required=response addr=0x%08h", addr);
      lat = -1;
    end
    bus.req_valid = 1'b0;
    bus.req_fence = 1'b0;
    bus.req_wstrb = '0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40 && dut.count_q != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 32'(dut.count_q), 32'd0);
  endtask

  typedef struct {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          exp_lat;
    logic        chk_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h100, 32'h0,        4'h0, 2, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h100, 32'h000000AA, 4'h1, 1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,        4'h0, 2, 1'b1, 32'hDEADBEAA};
    vecs[4]  = '{1'b0, 32'h104, 32'h12345678, 4'hC, 1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h104, 32'h0,        4'h0, 2, 1'b1, 32'h12340041};
    vecs[6]  = '{1'b0, 32'h108, 32'h0,        4'h0, 2, 1'b1, 32'hA5000042};
    vecs[7]  = '{1'b1, 32'h10C, 32'hFFFFFFFF, 4'hF, 1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h10C, 32'h0,        4'h0, 2, 1'b1, 32'hA5000043};
    vecs[9]  = '{1'b0, 32'h3FC, 32'hCAFEF00D, 4'h6, 1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h3FF, 32'h0,        4'h0, 2, 1'b1, 32'hA5FEF0FF};

    rst           = 1'b1;
    mem_clear     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_fence = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_clear = 1'b0;

    // Reset state
    check("rst_resp_ready", 32'(bus.resp_ready), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);

    // Store with memory always ready, then watch the drain write.
    run_req(1'b0, 32'h100, 32'hDEADBEEF, 4'hF, lat, rd);
    check("a_store_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 10 && !bus.mem_valid; i++) begin
      @(posedge clk); #1;
    end
    check("a_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("a_mem_addr", bus.mem_addr, 32'h100);
    check("a_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("a_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
    wait_empty("a_count_zero");

    // Table of single requests, each from an empty idle buffer.
    for (int i = 0; i < 11; i++) begin
      run_req(vecs[i].fence, vecs[i].addr, vecs[i].wdata, vecs[i].strb, lat, rd);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_data) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      repeat (8) @(posedge clk);
      #1;
    end

    // Forward hit with a stalled memory; youngest byte wins.
    bus.mem_ready = 1'b0;
    run_req(1'b0, 32'h200, 32'h11223344, 4'hF, lat, rd);
    check("b_store0_lat", 32'(lat), 32'd1);
    run_req(1'b0, 32'h200, 32'h000000AA, 4'h1, lat, rd);
    check("b_store1_lat", 32'(lat), 32'd1);
    run_req(1'b0, 32'h200, 32'h0, 4'h0, lat, rd);
    check("b_fwd_lat", 32'(lat), 32'd1);
    check("b_fwd_rdata", rd, 32'h112233AA);
    check("b_drain_addr", bus.mem_addr, 32'h200);
    check("b_drain_wstrb", 32'(bus.mem_wstrb), 32'hF);
    bus.mem_ready = 1'b1;
    wait_empty("b_count_zero");
    check("b_mem_word", mem[8'h80], 32'h112233AA);

    // Partial hazard: load waits for the drain, then reads memory.
    bus.mem_ready = 1'b0;
    run_req(1'b0, 32'h300, 32'h0000BEEF, 4'h3, lat, rd);
    check("c_store_lat", 32'(lat), 32'd1);
    fork
      run_req(1'b0, 32'h300, 32'h0, 4'h0, lat, rd);
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 10 && !(bus.mem_valid && bus.mem_wstrb == 4'h0); i++) begin
          @(posedge clk); #1;
        end
        check("c_rd_valid", 32'(bus.mem_valid), 32'd1);
        check("c_rd_addr", bus.mem_addr, 32'h300);
      end
    join
    check("c_load_lat", 32'(lat), 32'd8);
    check("c_load_rdata", rd, 32'hA500BEEF);

    // Full buffer: fifth store accepted on the first pop.
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, 32'h010 + 32'(4*i), 32'hD0D0_0001 + 32'(i), 4'hF, lat, rd);
      check($sformatf("d_store%0d_lat", i), 32'(lat), 32'd1);
    end
    check("d_count_full", 32'(dut.count_q), 32'd4);
    fork
      run_req(1'b0, 32'h020, 32'hD0D0_0005, 4'hF, lat, rd);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
    join
    check("d_store4_lat", 32'(lat), 32'd5);
    check("d_count_after", 32'(dut.count_q), 32'd4);
    check("d_tail_wrap", 32'(dut.tail_q), 32'd1);
    bus.mem_ready = 1'b1;
    wait_empty("d_count_zero");
    check("d_mem_first", mem[8'h04], 32'hD0D0_0001);
    check("d_mem_fifth", mem[8'h08], 32'hD0D0_0005);

    // Miss load beats the pending drain; fence follows the last drain.
    bus.mem_ready = 1'b0;
    run_req(1'b0, 32'h040, 32'h0A0B0C0D, 4'hF, lat, rd);
    check("e_store0_lat", 32'(lat), 32'd1);
    run_req(1'b0, 32'h044, 32'h01020304, 4'hF, lat, rd);
    check("e_store1_lat", 32'(lat), 32'd1);
    fork
      run_req(1'b0, 32'h080, 32'h0, 4'h0, lat, rd);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_valid; i++) begin
          @(posedge clk); #1;
        end
        check("e_load_addr", bus.mem_addr, 32'h080);
        check("e_load_wstrb", 32'(bus.mem_wstrb), 32'h0);
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
    join
    check("e_load_lat", 32'(lat), 32'd6);
    check("e_load_rdata", rd, 32'hA5000020);
    fork
      run_req(1'b1, 32'h0, 32'h0, 4'h0, lat, rd);
      begin
        check("e_drain1_addr", bus.mem_addr, 32'h044);
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
    join
    check("e_fence_lat", 32'(lat), 32'd4);
    check("e_count_zero", 32'(dut.count_q), 32'd0);

    // Reset in the middle of a drain discards everything.
    run_req(1'b0, 32'h060, 32'h11111111, 4'hF, lat, rd);
    run_req(1'b0, 32'h064, 32'h22222222, 4'hF, lat, rd);
    run_req(1'b0, 32'h068, 32'h33333333, 4'hF, lat, rd);
    check("f_count3", 32'(dut.count_q), 32'd3);
    check("f_draining", 32'(bus.mem_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("f_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("f_rst_count", 32'(dut.count_q), 32'd0);
    bus.mem_ready = 1'b1;
    run_req(1'b0, 32'h064, 32'h0, 4'h0, lat, rd);
    check("f_load_lat", 32'(lat), 32'd2);
    check("f_load_rdata", rd, 32'hA5000019);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Data-side memory front end between the execute stage's load/store/fence requests and the data memory port.
- Stores are posted into a DEPTH-entry FIFO and answered immediately. They drain to memory in order in the background.
- Loads are answered from buffered stores when the buffered data covers the whole word. Otherwise they are issued to memory, with hazard stalls on partial overlap.
- Fences complete only when the buffer is empty and memory is idle.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present; held stable by requester until resp_ready.
- req_addr  in  AW  byte address; bits [1:0] ignored, word granularity.
- req_wdata  in  DW  store data.
- req_wstrb  in  DW/8  byte strobes; nonzero means store, zero means load.
- req_fence  in  1  fence request; overrides wstrb.
- resp_ready  out  1  registered one-cycle completion pulse.
- resp_rdata  out  DW  load data, valid with resp_ready.
- mem_valid  out  1  memory request; held with fields stable until mem_ready.
- mem_addr  out  AW  word-aligned memory address.
- mem_wdata  out  DW  memory write data.
- mem_wstrb  out  DW/8  memory strobes; zero means read.
- mem_ready  in  1  memory completion pulse.
- mem_rdata  in  DW  memory read data, valid with mem_ready.

Behaviour:

Reset (rst=1 at a clock edge):
- resp_ready=0, resp_rdata=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- head=tail=count=0, all entries invalid, state IDLE.
- Reset mid-operation discards buffered stores and any outstanding memory op; mem_valid drops the next cycle.

Request sampling:
- req_valid is ignored in any cycle where resp_ready=1; that is the cycle the requester advances.
- At most one response per request.

Store:
- Accepted when count<DEPTH: entry written at tail, tail=tail+1 mod DEPTH, resp_ready=1 the next cycle.
- When full, the request waits; it is accepted in the cycle a drain pop frees a slot.
- Push and pop in the same cycle leave count unchanged.

Load, checked against all valid entries whose addr[AW-1:2] matches:
- Forward hit: the OR of matching strobes is all-ones. Data is merged per byte, youngest entry wins; resp_ready and resp_rdata arrive the next cycle.
- Clean miss: no matching entries. The load takes the memory port when state is IDLE; it has priority over drain.
- Partial hazard: some bytes covered, not all. The load waits until all matching entries have drained, then is handled as a clean miss.

Fence:
- resp_ready is pulsed the cycle after count==0 and state==IDLE.
- Stores that are not fences are blocked while a fence is pending; the requester holds anyway.

State machine (single outstanding memory op):
- IDLE -> LOAD: a clean-miss load is pending. Drive mem_valid=1, mem_addr={addr[AW-1:2],00}, mem_wstrb=0.
- IDLE -> DRAIN: no eligible load and count>0. Drive the head entry, mem_wstrb=entry strobes.
- LOAD -> IDLE: on mem_ready. Register resp_ready=1 and resp_rdata=mem_rdata; mem_valid=0.
- DRAIN -> IDLE: on mem_ready. Pop head, head=head+1 mod DEPTH, mem_valid=0.
- A draining head entry remains valid and forwardable until its pop.

Latency summary:
- Store accept or forward hit: 1 cycle.
- Load miss: mem_valid 1 cycle after request; resp 1 cycle after mem_ready.
- Pointers wrap modulo DEPTH. Count is never above DEPTH and never below 0.

Test Plan:
- Reset, then store addr 0x100 data 0xDEADBEEF strb 1111, mem_ready tied 1 → resp_ready at cycle+1; mem write to 0x100 with 0xDEADBEEF strb 1111 follows; count returns to 0.
- Stall memory (mem_ready=0), store 0x11223344 then 0x000000AA strb 0001 to 0x200, then load 0x200 → forward hit, resp_rdata=0x112233AA one cycle after the load.
- Buffer holds 0x300 strb 0011 only, load 0x300 → no response until that entry drains; then mem read of 0x300, and resp_rdata equals mem_rdata.
- Stall memory and issue 5 stores with DEPTH=4 → 4 resp pulses; 5th held until the first mem_ready, accepted the same cycle as the pop; count stays 4; tail wraps to 1.
- Two buffered stores, then a fence → resp_ready exactly one cycle after the second drain's mem_ready; a load to an unrelated address issued in IDLE goes before the pending drain.
- Assert rst while state is DRAIN with 3 entries → next cycle mem_valid=0, count=0; a subsequent load to a previously buffered address reads from memory.
